// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Shared definitions for the 13-bit Galois LFSR generator and
//                its receive-side checker: word width, seed, step function
//                and the checker's lock FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

  localparam int LFSR_W = 13;

  // Generator power-on seed; the first word a freshly reset generator emits.
  localparam logic [LFSR_W-1:0] LFSR_SEED = 13'h1FFF;

  // Checker lock state, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECKING = 2'd1,
    LOCKED   = 2'd2
  } lfsr_state_e;

  // One Galois step. Bit 9 is the feedback tap; it re-enters at bit 0 and is
  // XORed into bits 3, 4 and 7. Bit 10 is s[9]^s[9], i.e. always zero, which
  // is kept explicit so the generator and checker stay bit-exact.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] n;
    n[0]  = s[9];
    n[1]  = s[0];
    n[2]  = s[1];
    n[3]  = s[2] ^ s[9];
    n[4]  = s[3] ^ s[9];
    n[5]  = s[4];
    n[6]  = s[5];
    n[7]  = s[6] ^ s[9];
    n[8]  = s[7];
    n[9]  = s[8];
    n[10] = s[9] ^ s[9];
    n[11] = s[10];
    n[12] = s[11];
    return n;
  endfunction

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_checker
//  Description : Receive-side verifier for the 13-bit Galois LFSR stream.
//                Self-seeds from the incoming words, declares lock after
//                LOCK_COUNT consecutive correct predictions, then flywheels
//                through corrupted words and pulses err_pulse on each miss.
//                UNLOCK_THRESH consecutive misses drop lock.
//                Optional: define LFSR_CHECK_ERR_COUNT_EN to add the
//                saturating err_count output (width ERR_CNT_W).
//                A constant all-zero stream locks (step(0)=0); a genuine
//                generator never emits 0, so that lock means a stuck source.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT    = 4,   // 1..15
  parameter int UNLOCK_THRESH = 3    // 1..15
`ifdef LFSR_CHECK_ERR_COUNT_EN
  ,
  parameter int ERR_CNT_W     = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] data_in,
  input  logic              data_valid,
  output logic              locked,
  output logic              err_pulse,
  output logic [LFSR_W-1:0] expected
`ifdef LFSR_CHECK_ERR_COUNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  // Thresholds compared against the 4-bit run counter.
  localparam logic [3:0] LOCK_RUN   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_RUN = 4'(UNLOCK_THRESH);

  lfsr_state_e       state_q,     state_d;
  logic [LFSR_W-1:0] pred_q,      pred_d;
  logic [3:0]        run_q,       run_d;
  logic              locked_q,    locked_d;
  logic              err_pulse_q, err_pulse_d;

  logic [LFSR_W-1:0] step_data;
  logic [LFSR_W-1:0] step_pred;
  logic [3:0]        run_inc;
  logic              match;

  assign step_data = lfsr_step(data_in);
  assign step_pred = lfsr_step(pred_q);
  assign run_inc   = run_q + 4'd1;
  assign match     = (data_in == pred_q);

  // Next-state logic: acquisition reseeds from the incoming word, lock
  // flywheels on the prediction so a bad word can never poison it.
  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    run_d       = run_q;
    err_pulse_d = 1'b0;

    if (data_valid) begin
      unique case (state_q)
        UNLOCKED: begin
          pred_d  = step_data;
          run_d   = 4'd0;
          state_d = CHECKING;
        end

        CHECKING: begin
          // Match or not, the freshest word is the best seed available.
          pred_d = step_data;
          if (match) begin
            if (run_inc == LOCK_RUN) begin
              state_d = LOCKED;
              run_d   = 4'd0;
            end else begin
              run_d = run_inc;
            end
          end else begin
            run_d = 4'd0;
          end
        end

        LOCKED: begin
          pred_d = step_pred;
          if (match) begin
            run_d = 4'd0;
          end else begin
            // Every miss pulses, including the one that drops lock.
            err_pulse_d = 1'b1;
            if (run_inc == UNLOCK_RUN) begin
              state_d = UNLOCKED;
              run_d   = 4'd0;
            end else begin
              run_d = run_inc;
            end
          end
        end

        default: begin
          state_d = UNLOCKED;
          run_d   = 4'd0;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  // Registered state and outputs; reset abandons lock on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      pred_q      <= '0;
      run_q       <= 4'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      run_q       <= run_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign expected  = pred_q;

`ifdef LFSR_CHECK_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  // Saturating miss counter; survives unlock, cleared only by reset.
  always_comb begin
    err_count_d = err_count_q;
    if (err_pulse_d && (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule : lfsr_checker
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_checker
//  Description : Self-checking bench for lfsr_checker: a fixed vector table
//                for the lock / single-error path, hand sequences for the
//                unlock, reseed, gap and reset corners, then a randomized
//                stream checked against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_checker;
  import lfsr_pkg::*;

  localparam int LOCK_COUNT    = 4;
  localparam int UNLOCK_THRESH = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] data_in;
  logic        data_valid;
  logic        locked;
  logic        err_pulse;
  logic [12:0] expected;
`ifdef LFSR_CHECK_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lfsr_checker #(
    .LOCK_COUNT    (LOCK_COUNT),
    .UNLOCK_THRESH (UNLOCK_THRESH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .expected   (expected)
`ifdef LFSR_CHECK_ERR_COUNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  // Generator step written as shift-and-mask arithmetic.
  function automatic logic [12:0] ref_step(input logic [12:0] s);
    int v;
    v = (int'(s) << 1) & 32'h1FFF;
    v = v & ~(32'h1 << 10);
    if (s[9]) v = v ^ 32'h99;
    return 13'(v);
  endfunction

  // Reference model: words chained since the last seed sit in a queue; lock
  // once LOCK_COUNT+1 words chain. Locked, a free-running flywheel predicts.
  logic [12:0] acq_q[$];
  bit          m_locked;
  int          m_miss;
  logic [12:0] m_exp;
  bit          m_err;
  int          m_errcnt;

  task automatic model_reset();
    acq_q.delete();
    m_locked = 0; m_miss = 0; m_exp = '0; m_err = 0; m_errcnt = 0;
  endtask

  task automatic model_sample(input bit v, input logic [12:0] d);
    m_err = 0;
    if (!v) return;
    if (m_locked) begin
      if (d != m_exp) begin
        m_err = 1;
        m_miss++;
        if (m_errcnt < 65535) m_errcnt++;
      end else begin
        m_miss = 0;
      end
      m_exp = ref_step(m_exp);
      if (m_miss == UNLOCK_THRESH) begin
        m_locked = 0; m_miss = 0; acq_q.delete();
      end
    end else begin
      if (acq_q.size() > 0 && d == ref_step(acq_q[$])) acq_q.push_back(d);
      else begin
        acq_q.delete();
        acq_q.push_back(d);
      end
      m_exp = ref_step(d);
      if (acq_q.size() == LOCK_COUNT + 1) begin
        m_locked = 1; m_miss = 0; acq_q.delete();
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".locked"},    32'(locked),    32'(m_locked));
    check({tag, ".err_pulse"}, 32'(err_pulse), 32'(m_err));
    check({tag, ".expected"},  32'(expected),  32'(m_exp));
`ifdef LFSR_CHECK_ERR_COUNT_EN
    check({tag, ".err_count"}, 32'(err_count), 32'(m_errcnt));
`endif
  endtask

  // One clock: drive, take the edge, sample 1 time unit later.
  task automatic cyc(input bit v, input logic [12:0] d, input string tag);
    data_valid = v;
    data_in    = d;
    @(posedge clk);
    #1;
    model_sample(v, d);
    compare_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; data_valid = 1'b0; data_in = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    compare_all("reset");
  endtask

  typedef struct {
    bit          valid;
    logic [12:0] data;
    bit          exp_locked;
    bit          exp_err;
    logic [12:0] exp_pred;
  } vec_t;

  vec_t        tbl[9];
  logic [12:0] w[10];
  logic [12:0] g;
  logic [12:0] x;
  int          nvalid;
  bit          seen_lock;

  initial begin
    rst = 1'b1; data_valid = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // ---------------- table: lock, gap, single corrupted word ----------------
    w[0] = LFSR_SEED;
    for (int i = 1; i < 10; i++) w[i] = ref_step(w[i-1]);
    tbl[0] = '{1'b1, w[0],             1'b0, 1'b0, 13'h1B67};
    tbl[1] = '{1'b1, w[1],             1'b0, 1'b0, w[2]};
    tbl[2] = '{1'b1, w[2],             1'b0, 1'b0, w[3]};
    tbl[3] = '{1'b1, w[3],             1'b0, 1'b0, w[4]};
    tbl[4] = '{1'b1, w[4],             1'b1, 1'b0, w[5]};
    tbl[5] = '{1'b0, 13'h0AAA,         1'b1, 1'b0, w[5]};
    tbl[6] = '{1'b1, w[5],             1'b1, 1'b0, w[6]};
    tbl[7] = '{1'b1, w[6] ^ 13'h0001,  1'b1, 1'b1, w[7]};
    tbl[8] = '{1'b1, w[7],             1'b1, 1'b0, w[8]};
    for (int i = 0; i < 9; i++) begin
      data_valid = tbl[i].valid;
      data_in    = tbl[i].data;
      @(posedge clk);
      #1;
      model_sample(tbl[i].valid, tbl[i].data);
      check($sformatf("tbl%0d.locked", i),    32'(locked),    32'(tbl[i].exp_locked));
      check($sformatf("tbl%0d.err_pulse", i), 32'(err_pulse), 32'(tbl[i].exp_err));
      check($sformatf("tbl%0d.expected", i),  32'(expected),  32'(tbl[i].exp_pred));
    end
`ifdef LFSR_CHECK_ERR_COUNT_EN
    check("tbl.err_count", 32'(err_count), 32'd1);
`endif
    g = w[8];

    // ---------------- three consecutive misses drop lock ----------------
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, g ^ 13'h0100, $sformatf("miss%0d", i));
      check($sformatf("miss%0d.pulse", i), 32'(err_pulse), 32'd1);
      g = ref_step(g);
    end
    check("unlock.locked", 32'(locked), 32'd0);
    // Next valid word reseeds even though it is the true successor.
    cyc(1'b1, g, "reseed");
    check("reseed.expected", 32'(expected), 32'(ref_step(g)));
    g = ref_step(g);

    // ---------------- mismatch after two matches in CHECKING ----------------
    cyc(1'b1, g, "chk_m1"); g = ref_step(g);
    cyc(1'b1, g, "chk_m2"); g = ref_step(g);
    x = g ^ 13'h0421;
    cyc(1'b1, x, "chk_bad");
    check("chk_bad.err_pulse", 32'(err_pulse), 32'd0);
    g = ref_step(x);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, g, $sformatf("relock%0d", i));
      check($sformatf("relock%0d.locked", i), 32'(locked), (i == 3) ? 32'd1 : 32'd0);
      g = ref_step(g);
    end

    // ---------------- random valid gaps: lock counts valid words only ----------------
    do_reset();
    g = 13'($urandom_range(1, 8191));
    nvalid = 0;
    seen_lock = 0;
    for (int i = 0; i < 80 && !seen_lock; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        cyc(1'b0, 13'($urandom), "gap_idle");
      end else begin
        cyc(1'b1, g, "gap_valid");
        g = ref_step(g);
        nvalid++;
      end
      if (locked) begin
        seen_lock = 1;
        check("gap.valid_words_to_lock", 32'(nvalid), 32'(LOCK_COUNT + 1));
      end
    end
    if (!seen_lock) check("gap.lock_timeout", 32'd0, 32'd1);

    // ---------------- reset while locked with five logged errors ----------------
    do_reset();
    g = 13'($urandom_range(1, 8191));
    for (int i = 0; i < LOCK_COUNT + 1; i++) begin
      cyc(1'b1, g, "rl_lock"); g = ref_step(g);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, g ^ 13'h0010, "rl_err"); g = ref_step(g);
      cyc(1'b1, g, "rl_ok");             g = ref_step(g);
    end
    check("rl.locked_before", 32'(locked), 32'd1);
`ifdef LFSR_CHECK_ERR_COUNT_EN
    check("rl.err_count_before", 32'(err_count), 32'd5);
`endif
    rst = 1'b1; data_valid = 1'b1; data_in = g;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("rl.locked_after", 32'(locked), 32'd0);
    check("rl.expected_after", 32'(expected), 32'd0);
`ifdef LFSR_CHECK_ERR_COUNT_EN
    check("rl.err_count_after", 32'(err_count), 32'd0);
`endif
    for (int i = 0; i < LOCK_COUNT + 1; i++) begin
      cyc(1'b1, g, "rl_relock"); g = ref_step(g);
    end
    check("rl.relocked", 32'(locked), 32'd1);

    // ---------------- all-zero stream locks ----------------
    do_reset();
    for (int i = 0; i < LOCK_COUNT + 1; i++) cyc(1'b1, 13'h0000, "zero");
    check("zero.locked", 32'(locked), 32'd1);

    // ---------------- randomized stream vs reference model ----------------
    do_reset();
    g = 13'($urandom_range(1, 8191));
    for (int i = 0; i < 1500; i++) begin
      int r;
      bit v;
      r = $urandom_range(0, 99);
      v = ($urandom_range(0, 9) < 7);
      if (r < 8)       x = g ^ (13'h0001 << $urandom_range(0, 12));
      else if (r < 10) x = 13'($urandom);
      else             x = g;
      cyc(v, x, "rnd");
      if (v) g = ref_step(g);
      if (r == 99) g = 13'($urandom_range(1, 8191));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_lfsr_checker
`default_nettype wire
